// File: rtl/demo1_helloworld_ram_arb_pkg.sv
// Shared constants for the two-master program/data RAM arbiter.
// Holds master IDs, default widths and the out-of-range helper.
package demo1_helloworld_ram_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 2560;

    localparam logic M_IFETCH = 1'b0;
    localparam logic M_DATA   = 1'b1;

    localparam logic [31:0] OOR_RDATA_DEF = 32'h0000_0000;

    function automatic logic addr_oor(input logic [31:0] addr, input logic [31:0] depth);
        return (addr >= depth);
    endfunction

endpackage

// File: rtl/demo1_helloworld_ram_arbiter_rr_arbiter_2.sv
// Two-requester round-robin arbiter: one-hot grant, the last winner loses ties.
// The last-grant register resets to the data master so the fetch master wins first.
module rr_arbiter_2
    import demo1_helloworld_ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

    logic r_last_grant;

    // Grant selection from the request pair and the previous winner.
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_last_grant == M_DATA) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    // Remember the winner of every accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= M_DATA;
        end else if (|o_grant) begin
            r_last_grant <= o_grant[1];
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

endmodule

// File: rtl/demo1_helloworld_ram_arbiter.sv
// Shares the single-port program/data RAM between the instruction master (m0, read-only)
// and the data/DMA master (m1), with a one-stage tagged read-response pipeline.
module demo1_helloworld_ram_arbiter
    import demo1_helloworld_ram_arb_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DEPTH     = DEPTH_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] OOR_RDATA = OOR_RDATA_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     ram_address,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic [DATA_W-1:0]     ram_writedata,
    input  logic [DATA_W-1:0]     ram_readdata,
    output logic                  busy
);

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_accept;
    logic              w_sel;
    logic              w_wr;
    logic              w_oor;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused_m0_write;

    logic r_rsp_valid;
    logic r_rsp_id;
    logic r_rsp_oor;

    // m0 is read-only, so its write strobe is deliberately left unconnected.
    assign w_unused_m0_write = m0_write;

    // Requests are masked while in reset so nothing is granted or issued.
    assign w_req[0] = m0_read & reset_n;
    assign w_req[1] = (m1_read | m1_write) & reset_n;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_req   (w_req),
        .o_grant (w_grant)
    );

    assign w_accept = |w_grant;
    assign w_sel    = w_grant[1];
    assign w_addr   = w_sel ? m1_address : m0_address;
    assign w_wr     = w_sel & m1_write;
    assign w_oor    = addr_oor(32'(w_addr), 32'(DEPTH));

    assign m0_waitrequest = ~reset_n | (w_req[0] & ~w_grant[0]);
    assign m1_waitrequest = ~reset_n | (w_req[1] & ~w_grant[1]);

    // Out-of-range writes are dropped; out-of-range reads still strobe the RAM
    // but their data is replaced on the response side.
    assign ram_address    = w_addr;
    assign ram_chipselect = w_accept & ~(w_wr & w_oor);
    assign ram_write      = w_accept & w_wr & ~w_oor;
    assign ram_byteenable = w_sel ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = w_sel ? m1_writedata  : m0_writedata;

    // Response pipeline: one stage, matching the RAM read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= M_IFETCH;
            r_rsp_oor   <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept & ~w_wr;
            r_rsp_id    <= w_sel;
            r_rsp_oor   <= w_oor;
        end
    end

    assign w_rdata          = r_rsp_oor ? OOR_RDATA : ram_readdata;
    assign m0_readdata      = w_rdata;
    assign m1_readdata      = w_rdata;
    assign m0_readdatavalid = r_rsp_valid & (r_rsp_id == M_IFETCH);
    assign m1_readdatavalid = r_rsp_valid & (r_rsp_id == M_DATA);
    assign busy             = w_accept | r_rsp_valid;

endmodule
